ex_stage: RTL

- Execute stage of the 5-stage pipeline CPU. It sits between the ID/EX register (driven by decode) and the memory stage.
- It contains:
  - the operand-forwarding muxes,
  - the ALU,
  - the branch-target adder,
  - an iterative 32-cycle multiplier with a pipeline-stall handshake,
  - the EX/MEM pipeline register.
- Its registered outputs connect directly to the memory stage's branch_pc/result/zero/read_data2/write_reg/WB/MEM control inputs.

---
 rtl/ex_stage_pkg.sv | 43 ++++
 rtl/ex_stage_mul_seq.sv | 110 +++++++++++
 rtl/ex_stage.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_pkg.sv
// ----------------------------------------------------------------------------
// ex_stage_pkg
// Shared constants for the execute stage: ALU operation codes, R-type funct
// codes, forwarding-select codes, EX_control bit positions and the state
// encoding of the iterative multiplier.
// No ports (package only).
// ----------------------------------------------------------------------------
package ex_stage_pkg;

    // alu_op field of EX_control
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
    localparam logic [1:0] ALU_OP_ADD2  = 2'b11;

    // R-type funct codes
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;
    localparam logic [5:0] FUNCT_MUL = 6'h18;

    // Forwarding selects (11 falls back to the register value)
    localparam logic [1:0] FWD_REG     = 2'b00;
    localparam logic [1:0] FWD_WB      = 2'b01;
    localparam logic [1:0] FWD_MEM     = 2'b10;
    localparam logic [1:0] FWD_REG_ALT = 2'b11;

    // EX_control bit positions
    localparam int EX_REG_DST   = 0;
    localparam int EX_ALU_SRC   = 1;
    localparam int EX_ALU_OP_LO = 2;
    localparam int EX_ALU_OP_HI = 3;

    // Multiplier FSM states
    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_BUSY = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_t;

endpackage

// File: rtl/ex_stage_mul_seq.sv
// ----------------------------------------------------------------------------
// mul_seq
// Iterative shift-add multiplier producing the low 32 bits of a*b.
// Ports:
//   i_clk, i_rst_n  clock, synchronous active-low reset
//   i_start         latch i_a/i_b and begin (honoured only in IDLE)
//   i_abort         drop an operation in progress and return to IDLE
//   i_a, i_b        operands
//   o_state         current FSM state (also used by the parent for control)
//   o_product       running / final product (valid in DONE)
//
// Handshake: the parent raises i_start for one cycle while o_state is IDLE.
// The FSM then spends MUL_CYCLES cycles in BUSY (one shift-add step each)
// and exactly one cycle in DONE, during which o_product is final, before it
// returns unconditionally to IDLE. There is no backpressure on DONE.
// ----------------------------------------------------------------------------
module mul_seq
    import ex_stage_pkg::*;
#(
    parameter int MUL_CYCLES = 32
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output mul_state_t  o_state,
    output logic [31:0] o_product
);

    localparam int CW = $clog2(MUL_CYCLES);
    localparam logic [CW-1:0] LAST_STEP = CW'(MUL_CYCLES - 1);

    mul_state_t    r_state;
    mul_state_t    w_next_state;
    logic [CW-1:0] r_count;
    logic [31:0]   r_mcand;
    logic [31:0]   r_mplier;
    logic [31:0]   r_product;

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            MUL_IDLE: begin
                if (i_start) begin
                    w_next_state = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                if (i_abort) begin
                    w_next_state = MUL_IDLE;
                end else if (r_count == LAST_STEP) begin
                    w_next_state = MUL_DONE;
                end
            end
            MUL_DONE: begin
                w_next_state = MUL_IDLE;
            end
            default: begin
                w_next_state = MUL_IDLE;
            end
        endcase
    end

    // State register and datapath
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= MUL_IDLE;
            r_count   <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_product <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                MUL_IDLE: begin
                    if (i_start) begin
                        r_mcand   <= i_a;
                        r_mplier  <= i_b;
                        r_product <= '0;
                        r_count   <= '0;
                    end
                end
                MUL_BUSY: begin
                    if (i_abort) begin
                        r_count <= '0;
                    end else begin
                        // Only the low 32 bits matter, so the multiplicand
                        // is shifted left within 32 bits and bits pushed out
                        // are simply lost.
                        if (r_mplier[0]) begin
                            r_product <= r_product + r_mcand;
                        end
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_count  <= (r_count == LAST_STEP) ? '0 : r_count + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_state   = r_state;
    assign o_product = r_product;

endmodule

// File: rtl/ex_stage.sv
// ----------------------------------------------------------------------------
// ex_stage
// Execute stage of the 5-stage pipeline: operand forwarding, ALU, branch
// target adder, iterative multiplier with stall handshake and the EX/MEM
// pipeline register.
// Ports:
//   i_clk, i_rst_n                clock, synchronous active-low reset
//   i_pc_plus4, i_read_data1/2,
//   i_sign_ext_imm, i_rt, i_rd,
//   i_funct, i_EX_control,
//   i_MEM_control, i_WB_control   ID/EX register contents
//   i_fwd_a_sel, i_fwd_b_sel      forwarding selects
//   i_fwd_mem_result, i_fwd_wb_data forwarded values
//   i_flush                       squash the instruction in EX
//   o_stall                       combinational: hold PC/IF/ID/ID-EX
//   o_branch_pc .. o_MEM_control  EX/MEM register outputs
// ----------------------------------------------------------------------------
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int MUL_CYCLES = 32
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_pc_plus4,
    input  logic [31:0] i_read_data1,
    input  logic [31:0] i_read_data2,
    input  logic [31:0] i_sign_ext_imm,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [5:0]  i_funct,
    input  logic [3:0]  i_EX_control,
    input  logic [2:0]  i_MEM_control,
    input  logic [1:0]  i_WB_control,
    input  logic [1:0]  i_fwd_a_sel,
    input  logic [1:0]  i_fwd_b_sel,
    input  logic [31:0] i_fwd_mem_result,
    input  logic [31:0] i_fwd_wb_data,
    input  logic        i_flush,
    output logic        o_stall,
    output logic [31:0] o_branch_pc,
    output logic [31:0] o_result,
    output logic        o_zero,
    output logic [31:0] o_read_data2,
    output logic [4:0]  o_write_reg,
    output logic [1:0]  o_WB_control,
    output logic [2:0]  o_MEM_control
);

    logic [1:0]  w_alu_op;
    logic [31:0] w_fwd_a;
    logic [31:0] w_fwd_b;
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_result;
    logic [31:0] w_branch_pc;
    logic [4:0]  w_write_reg;
    logic        w_is_mul;
    logic        w_mul_start;
    logic        w_mul_idle;
    logic        w_mul_busy;
    mul_state_t  w_mul_state;
    logic [31:0] w_mul_product;

    logic [31:0] r_branch_pc;
    logic [31:0] r_result;
    logic        r_zero;
    logic [31:0] r_read_data2;
    logic [4:0]  r_write_reg;
    logic [1:0]  r_WB_control;
    logic [2:0]  r_MEM_control;

    assign w_alu_op = i_EX_control[EX_ALU_OP_HI:EX_ALU_OP_LO];

    // Operand forwarding
    always_comb begin
        w_fwd_a = i_read_data1;
        case (i_fwd_a_sel)
            FWD_WB:  w_fwd_a = i_fwd_wb_data;
            FWD_MEM: w_fwd_a = i_fwd_mem_result;
            default: w_fwd_a = i_read_data1;
        endcase
    end

    always_comb begin
        w_fwd_b = i_read_data2;
        case (i_fwd_b_sel)
            FWD_WB:  w_fwd_b = i_fwd_wb_data;
            FWD_MEM: w_fwd_b = i_fwd_mem_result;
            default: w_fwd_b = i_read_data2;
        endcase
    end

    assign w_alu_b     = i_EX_control[EX_ALU_SRC] ? i_sign_ext_imm : w_fwd_b;
    assign w_write_reg = i_EX_control[EX_REG_DST] ? i_rd : i_rt;
    assign w_branch_pc = i_pc_plus4 + {i_sign_ext_imm[29:0], 2'b00};

    // ALU; the mul case reads the multiplier product, which is only
    // final (and only captured) in the DONE cycle.
    always_comb begin
        w_alu_result = '0;
        case (w_alu_op)
            ALU_OP_ADD:  w_alu_result = w_fwd_a + w_alu_b;
            ALU_OP_SUB:  w_alu_result = w_fwd_a - w_alu_b;
            ALU_OP_ADD2: w_alu_result = w_fwd_a + w_alu_b;
            ALU_OP_RTYPE: begin
                case (i_funct)
                    FUNCT_ADD: w_alu_result = w_fwd_a + w_alu_b;
                    FUNCT_SUB: w_alu_result = w_fwd_a - w_alu_b;
                    FUNCT_AND: w_alu_result = w_fwd_a & w_alu_b;
                    FUNCT_OR:  w_alu_result = w_fwd_a | w_alu_b;
                    FUNCT_SLT: w_alu_result = ($signed(w_fwd_a) < $signed(w_alu_b)) ? 32'd1 : 32'd0;
                    FUNCT_MUL: w_alu_result = w_mul_product;
                    default:   w_alu_result = '0;
                endcase
            end
            default: w_alu_result = '0;
        endcase
    end

    // Multiplier control
    assign w_is_mul    = (w_alu_op == ALU_OP_RTYPE) && (i_funct == FUNCT_MUL);
    assign w_mul_idle  = (w_mul_state == MUL_IDLE);
    assign w_mul_busy  = (w_mul_state == MUL_BUSY);
    assign w_mul_start = w_mul_idle && w_is_mul && !i_flush;

    // Stall covers the IDLE cycle that launches the multiply plus every
    // BUSY cycle; flush and reset both override it so the squash/reset
    // takes effect in the same cycle.
    assign o_stall = i_rst_n && !i_flush && ((w_mul_idle && w_is_mul) || w_mul_busy);

    mul_seq #(
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul_seq (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_start   (w_mul_start),
        .i_abort   (i_flush),
        .i_a       (w_fwd_a),
        .i_b       (w_fwd_b),
        .o_state   (w_mul_state),
        .o_product (w_mul_product)
    );

    // EX/MEM register: flush and stall both insert a bubble so the memory
    // stage sees a multiply exactly once, on the edge that leaves DONE.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_branch_pc   <= '0;
            r_result      <= '0;
            r_zero        <= 1'b0;
            r_read_data2  <= '0;
            r_write_reg   <= '0;
            r_WB_control  <= '0;
            r_MEM_control <= '0;
        end else if (i_flush || o_stall) begin
            r_branch_pc   <= '0;
            r_result      <= '0;
            r_zero        <= 1'b0;
            r_read_data2  <= '0;
            r_write_reg   <= '0;
            r_WB_control  <= '0;
            r_MEM_control <= '0;
        end else begin
            r_branch_pc   <= w_branch_pc;
            r_result      <= w_alu_result;
            r_zero        <= (w_alu_result == 32'd0);
            r_read_data2  <= w_fwd_b;
            r_write_reg   <= w_write_reg;
            r_WB_control  <= i_WB_control;
            r_MEM_control <= i_MEM_control;
        end
    end

    assign o_branch_pc   = r_branch_pc;
    assign o_result      = r_result;
    assign o_zero        = r_zero;
    assign o_read_data2  = r_read_data2;
    assign o_write_reg   = r_write_reg;
    assign o_WB_control  = r_WB_control;
    assign o_MEM_control = r_MEM_control;

endmodule
